// File: rtl/ldm_pkg.sv
// Shared types for the laser distance meter: FSM state encoding and width.
package ldm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    FIRE    = 3'd2,
    MEASURE = 3'd3,
    UPDATE  = 3'd4
  } ldm_state_e;

  // A button press is a 0->1 transition between consecutive samples.
  function automatic logic rising(input logic now, input logic prev);
    return now & ~prev;
  endfunction

endpackage

// File: rtl/ldm_counter.sv
// Clear/enable up-counter that saturates at a terminal count; used for the
// laser pulse length and for the echo round-trip time.
module ldm_counter
  import ldm_pkg::*;
#(
  parameter int W  = 16,
  parameter int TC = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = W'(TC);

  logic [W-1:0] cnt_r;

  assign cnt = cnt_r;
  assign tc  = (cnt_r == TC_VAL);

  // count register; holding at the terminal count keeps it from ever wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !tc) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/laser_distance_meter_param.sv
// Laser distance meter: fires a pulse on a button press and reports half the
// echo round-trip cycle count. Define LDM_AVG_EN to average 2^AVG_LOG shots.
module laser_distance_meter_param
  import ldm_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 65535,
  parameter int AVG_LOG   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             B,
  input  logic             S,
  output logic             L,
  output logic [CNT_W-1:0] D,
  output logic             valid,
  output logic             err
);

  localparam longint MAX_CNT = (64'd1 << CNT_W) - 64'd1;

  if (PULSE_LEN < 1 || PULSE_LEN > 255 || longint'(PULSE_LEN) > MAX_CNT ||
      TIMEOUT < 2 || longint'(TIMEOUT) > MAX_CNT) begin : g_bad_param
    $error("laser_distance_meter_param: PULSE_LEN or TIMEOUT out of range");
  end

  ldm_state_e       state_r;
  ldm_state_e       state_nxt_s;
  logic             b_prev_r;
  logic             b_edge_s;
  logic             rt_clr_s;
  logic             rt_en_s;
  logic [CNT_W-1:0] rt_cnt_s;
  logic             rt_tc_s;
  logic             pls_clr_s;
  logic             pls_en_s;
  logic [CNT_W-1:0] pls_cnt_s;
  logic             pls_tc_s;
  logic             latch_s;
  logic             timeout_s;
  logic             update_s;
  logic             l_r;
  logic [CNT_W-1:0] d_r;
  logic             valid_r;
  logic             err_r;
  logic [CNT_W-1:0] lat_r;
  logic             unused_s;

  assign b_edge_s = rising(B, b_prev_r);
  assign L        = l_r;
  assign D        = d_r;
  assign valid    = valid_r;
  assign err      = err_r;
  assign unused_s = ^pls_cnt_s;

  ldm_counter #(.W(CNT_W), .TC(PULSE_LEN - 1)) u_pulse_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (pls_clr_s),
    .en    (pls_en_s),
    .cnt   (pls_cnt_s),
    .tc    (pls_tc_s)
  );

  ldm_counter #(.W(CNT_W), .TC(TIMEOUT - 1)) u_rt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (rt_clr_s),
    .en    (rt_en_s),
    .cnt   (rt_cnt_s),
    .tc    (rt_tc_s)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    rt_clr_s    = 1'b0;
    rt_en_s     = 1'b0;
    pls_clr_s   = 1'b0;
    pls_en_s    = 1'b0;
    latch_s     = 1'b0;
    timeout_s   = 1'b0;
    update_s    = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = ARMED;
      end
      ARMED: begin
        if (b_edge_s) begin
          state_nxt_s = FIRE;
          rt_clr_s    = 1'b1;
          pls_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      FIRE: begin
        rt_en_s  = 1'b1;
        pls_en_s = 1'b1;
        if (pls_tc_s) begin
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = FIRE;
        end
      end
      MEASURE: begin
        rt_en_s = 1'b1;
        // an echo arriving on the last allowed cycle still counts as a hit
        if (S) begin
          latch_s     = 1'b1;
          state_nxt_s = UPDATE;
        end else if (rt_tc_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      UPDATE: begin
        update_s    = 1'b1;
        state_nxt_s = ARMED;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // button history, laser enable and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_prev_r <= 1'b0;
      l_r      <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      b_prev_r <= B;
      l_r      <= (state_nxt_s == FIRE);
      if (timeout_s) begin
        err_r <= 1'b1;
      end else if (rt_clr_s) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // round-trip count captured when the echo is seen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_r <= '0;
    end else if (latch_s) begin
      lat_r <= rt_cnt_s;
    end else begin
      lat_r <= lat_r;
    end
  end

`ifdef LDM_AVG_EN
  localparam int                ACC_W     = CNT_W + AVG_LOG;
  localparam int                SH_W      = AVG_LOG + 1;
  localparam logic [SH_W-1:0]   LAST_SHOT = SH_W'((1 << AVG_LOG) - 1);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic [SH_W-1:0]  shots_r;

  assign sum_s = acc_r + ACC_W'(lat_r);

  // accumulate shots; publish the halved mean once the batch is complete
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r   <= '0;
      shots_r <= '0;
      d_r     <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (timeout_s) begin
        acc_r   <= '0;
        shots_r <= '0;
      end else if (update_s) begin
        if (shots_r == LAST_SHOT) begin
          d_r     <= CNT_W'(sum_s >> (AVG_LOG + 1));
          valid_r <= 1'b1;
          acc_r   <= '0;
          shots_r <= '0;
        end else begin
          acc_r   <= sum_s;
          shots_r <= shots_r + SH_W'(1);
        end
      end else begin
        acc_r   <= acc_r;
        shots_r <= shots_r;
      end
    end
  end
`else
  // every successful shot publishes half its round-trip count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_r     <= '0;
      valid_r <= 1'b0;
    end else if (update_s) begin
      d_r     <= lat_r >> 1;
      valid_r <= 1'b1;
    end else begin
      d_r     <= d_r;
      valid_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_laser_distance_meter_param.sv
// Directed self-checking bench for laser_distance_meter_param
// (CNT_W=16, PULSE_LEN=2, TIMEOUT=1000, AVG_LOG=2).
module tb_laser_distance_meter_param;

  localparam int CNT_W     = 16;
  localparam int PULSE_LEN = 2;
  localparam int TIMEOUT   = 1000;
  localparam int AVG_LOG   = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             B     = 1'b0;
  logic             S     = 1'b0;
  logic             L;
  logic             valid;
  logic             err;
  logic [CNT_W-1:0] D;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   l_rise   = 0;
  logic l_prev   = 1'b0;

  always #5 clk = ~clk;

  laser_distance_meter_param #(
    .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .AVG_LOG(AVG_LOG)
  ) dut (
    .clk(clk), .reset(reset), .B(B), .S(S), .L(L), .D(D), .valid(valid), .err(err)
  );

  // count laser pulses, sampled away from the active edge
  always @(negedge clk) begin
    l_prev <= L;
    if (L && !l_prev) l_rise <= l_rise + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One shot: echo presented while the round-trip counter equals s_at.
  task automatic shot(input string tag, input int s_at, input bit hold_b, input bit chk_l,
                      input int exp_v, input logic [15:0] exp_d);
    int e;
    int vcnt;
    @(posedge clk); #1 B = 1'b1;
    @(posedge clk); #1;
    if (!hold_b) B = 1'b0;
    e = 0;
    if (chk_l) begin
      @(negedge clk); check_eq({tag, "_l0"}, 32'(L), 32'd1);
      @(posedge clk); e = 1;
      @(negedge clk); check_eq({tag, "_l1"}, 32'(L), 32'd1);
      @(posedge clk); e = 2;
      @(negedge clk); check_eq({tag, "_l2"}, 32'(L), 32'd0);
    end
    while (e < s_at) begin
      @(posedge clk); e++;
    end
    #1 S = 1'b1;
    @(posedge clk); #1 S = 1'b0;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check_eq({tag, "_valid_cnt"}, 32'(vcnt), 32'(exp_v));
    check_eq({tag, "_d"}, 32'(D), 32'(exp_d));
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Shot with no echo: err must rise when the counter reaches TIMEOUT-1.
  task automatic timeout_shot(input string tag, input logic [15:0] exp_d);
    int n;
    int vseen;
    @(posedge clk); #1 B = 1'b1;
    @(posedge clk); #1 B = 1'b0;
    n = 0;
    vseen = 0;
    while (n < 1100) begin
      @(negedge clk);
      if (valid) vseen++;
      if (err) break;
      @(posedge clk);
      n++;
    end
    check_eq({tag, "_cycle"}, 32'(n), 32'd1000);
    check_eq({tag, "_err"}, 32'(err), 32'd1);
    check_eq({tag, "_no_valid"}, 32'(vseen), 32'd0);
    check_eq({tag, "_d_kept"}, 32'(D), 32'(exp_d));
  endtask

  // Reset asserted in MEASURE at counter 50; outputs must clear without a clock.
  task automatic reset_mid(input string tag);
    @(posedge clk); #1 B = 1'b1;
    @(posedge clk); #1 B = 1'b0;
    repeat (49) @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check_eq({tag, "_l"}, 32'(L), 32'd0);
    check_eq({tag, "_d"}, 32'(D), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int r0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_l", 32'(L), 32'd0);
    check_eq("rst_d", 32'(D), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);

`ifdef LDM_AVG_EN
    // (20+22+24+26)/4 = 23, halved -> 11
    shot("avg_a0", 20, 1'b0, 1'b1, 0, 16'd0);
    shot("avg_a1", 22, 1'b0, 1'b0, 0, 16'd0);
    shot("avg_a2", 24, 1'b0, 1'b0, 0, 16'd0);
    shot("avg_a3", 26, 1'b0, 1'b0, 1, 16'd11);
    // partial batch discarded by the timeout; fresh batch of 40s -> 20
    shot("avg_b0", 100, 1'b0, 1'b0, 0, 16'd11);
    shot("avg_b1", 100, 1'b0, 1'b0, 0, 16'd11);
    timeout_shot("avg_to", 16'd11);
    shot("avg_c0", 40, 1'b0, 1'b0, 0, 16'd11);
    shot("avg_c1", 40, 1'b0, 1'b0, 0, 16'd11);
    shot("avg_c2", 40, 1'b0, 1'b0, 0, 16'd11);
    shot("avg_c3", 40, 1'b0, 1'b0, 1, 16'd20);
`else
    shot("single", 20, 1'b0, 1'b1, 1, 16'd10);
    timeout_shot("timeout", 16'd10);
    shot("edge999", 999, 1'b0, 1'b0, 1, 16'd499);
    r0 = l_rise;
    shot("held", 40, 1'b1, 1'b0, 1, 16'd20);
    repeat (150) @(posedge clk);
    #1;
    check_eq("held_one_fire", 32'(l_rise - r0), 32'd1);
    B = 1'b0;
    @(posedge clk);
    reset_mid("rst_mid");
    shot("after_rst", 30, 1'b0, 1'b1, 1, 16'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
